// File: rtl/pad_mux_config_ctrl.sv
// rtl/pad_mux_config_ctrl.sv - pad-mux configuration sequencer
// Gates pad OEs around every selector change: isolate, switch, settle, re-enable.
module pad_mux_config_ctrl #(
  parameter int NUM_CFG       = 4,
  parameter int ISO_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_cfg,
  output logic       req_ready,
  output logic [3:0] configuration,
  output logic       oe_gate,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYC = (ISO_CYCLES > SETTLE_CYCLES) ? ISO_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {BOOT, IDLE, ISOLATE, SWITCH, SETTLE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     pending;
  logic           accept, cfg_illegal, cfg_same;
  logic           done_n, err_n;

  // Acceptance keys off the state, not req_ready, so it needs no extra register stage.
  assign accept      = req_valid && (state == IDLE);
  assign cfg_illegal = ({1'b0, req_cfg} >= 5'(NUM_CFG));
  assign cfg_same    = (req_cfg == configuration);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      BOOT: begin
        if (cnt <= CW'(1)) state_n = IDLE;
        else               cnt_n   = cnt - CW'(1);
      end
      IDLE: begin
        if (accept) begin
          if (cfg_illegal)   err_n  = 1'b1;
          else if (cfg_same) done_n = 1'b1;
          else begin
            state_n = ISOLATE;
            cnt_n   = CW'(ISO_CYCLES);
          end
        end
      end
      ISOLATE: begin
        if (cnt <= CW'(1)) state_n = SWITCH;
        else               cnt_n   = cnt - CW'(1);
      end
      SWITCH: begin
        state_n = SETTLE;
        cnt_n   = CW'(SETTLE_CYCLES);
      end
      SETTLE: begin
        if (cnt <= CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = BOOT;
        cnt_n   = CW'(SETTLE_CYCLES);
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      cnt           <= CW'(SETTLE_CYCLES);
      pending       <= 4'd0;
      configuration <= 4'd0;
      oe_gate       <= 1'b0;
      req_ready     <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if (accept) pending <= req_cfg;
      if (state == SWITCH) configuration <= pending;
      oe_gate   <= (state_n == IDLE);
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_pad_mux_config_ctrl.sv
// tb/tb_pad_mux_config_ctrl.sv - scoreboard bench for pad_mux_config_ctrl
// Stimulus pushes expected done/err events; a monitor pops them as pulses appear.
module tb_pad_mux_config_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_cfg = 4'd0;
  logic       req_ready;
  logic [3:0] configuration;
  logic       oe_gate;
  logic       busy;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [3:0] cur_cfg = 4'd0;

  typedef struct {
    bit         is_err;
    logic [3:0] cfg;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  pad_mux_config_ctrl #(.NUM_CFG(4), .ISO_CYCLES(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cfg(req_cfg),
    .req_ready(req_ready), .configuration(configuration), .oe_gate(oe_gate),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [3:0] c);
    exp_t e;
    req_valid = 1'b1;
    req_cfg   = c;
    chk("req_ready_at_issue", req_ready, 1);
    if (c >= 4)            e = '{is_err: 1'b1, cfg: cur_cfg, at: cyc + 1};
    else if (c == cur_cfg) e = '{is_err: 1'b0, cfg: cur_cfg, at: cyc + 1};
    else begin
      e = '{is_err: 1'b0, cfg: c, at: cyc + 14};
      cur_cfg = c;
    end
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done || err) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse @cyc %0d: got done=%0b err=%0b, want none", cyc, done, err);
      end else begin
        e = exp_q.pop_front();
        if (done !== !e.is_err || err !== e.is_err || configuration !== e.cfg || cyc != e.at) begin
          miscompares++;
          $display("FAIL pulse @cyc %0d: got done=%0b err=%0b cfg=%0d, want done=%0b err=%0b cfg=%0d at cyc %0d",
                   cyc, done, err, configuration, !e.is_err, e.is_err, e.cfg, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;

    // Reset and boot
    #1 rst_n = 1'b0;
    #1;
    chk("rst_configuration", configuration, 0);
    chk("rst_oe_gate", oe_gate, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    r = cyc;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        chk("boot_oe_edge3", oe_gate, 0);
        chk("boot_ready_edge3", req_ready, 0);
      end
      if (i == 4) begin
        chk("boot_oe_edge4", oe_gate, 1);
        chk("boot_ready_edge4", req_ready, 1);
        chk("boot_busy_edge4", busy, 0);
      end
    end

    // Normal change 0 -> 2
    k = cyc;
    issue(4'd2);
    chk("iso_oe_c1", oe_gate, 0);
    chk("iso_busy_c1", busy, 1);
    wait_until(k + 9);
    chk("switch_oe_c9", oe_gate, 0);
    chk("switch_cfg_c9", configuration, 0);
    wait_until(k + 10);
    chk("settle_cfg_c10", configuration, 2);
    chk("settle_oe_c10", oe_gate, 0);
    wait_until(k + 11);
    chk("settle_oe_c11", oe_gate, 0);
    wait_until(k + 13);
    chk("settle_oe_c13", oe_gate, 0);
    wait_until(k + 14);
    chk("idle_oe_c14", oe_gate, 1);
    chk("idle_ready_c14", req_ready, 1);
    tick();

    // Same-config request
    issue(4'd2);
    chk("same_oe", oe_gate, 1);
    chk("same_ready", req_ready, 1);
    tick();
    chk("same_oe_after", oe_gate, 1);

    // Illegal request, then a legal one
    issue(4'd5);
    chk("illegal_cfg", configuration, 2);
    chk("illegal_oe", oe_gate, 1);
    chk("illegal_ready", req_ready, 1);
    tick();
    k = cyc;
    issue(4'd0);
    wait_until(k + 14);
    chk("legal_after_err_cfg", configuration, 0);
    chk("legal_after_err_oe", oe_gate, 1);
    tick();

    // Busy requests ignored, then back-to-back acceptance
    k = cyc;
    issue(4'd1);
    while (cyc < k + 14) begin
      chk("busy_ready_low", req_ready, 0);
      req_valid = cyc[0];
      req_cfg   = 4'd3;
      tick();
    end
    chk("b2b_cfg_is_1", configuration, 1);
    k = cyc;
    issue(4'd3);
    wait_until(k + 15);
    chk("b2b_cfg_is_3", configuration, 3);

    // Reset mid-ISOLATE
    k = cyc;
    issue(4'd0);
    wait_until(k + 5);
    chk("pre_abort_oe", oe_gate, 0);
    chk("pre_abort_cfg", configuration, 3);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    cur_cfg = 4'd0;
    chk("abort_cfg", configuration, 0);
    chk("abort_oe", oe_gate, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    wait_until(r + 3);
    chk("reboot_oe_edge3", oe_gate, 0);
    wait_until(r + 4);
    chk("reboot_oe_edge4", oe_gate, 1);
    chk("reboot_busy_edge4", busy, 0);
    chk("reboot_cfg", configuration, 0);
    repeat (20) tick();

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
